hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit.sv | 118 +++++++++++
 tb/tb_hazard_unit.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: X/M operand forwarding selects, load-use and HI/LO
// interlock, and a saturating count of interlock cycles.
module hazard_unit #(
   parameter int unsigned MUL_LAT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  d_rs_a,
   input  logic [4:0]  d_rt_a,
   input  logic        d_use_rs,
   input  logic        d_use_rt,
   input  logic [4:0]  d_rd_a,
   input  logic        d_reg_write,
   input  logic        d_mem_read,
   input  logic        d_mul,
   input  logic        d_use_hilo,
   input  logic        flush,
   output logic        fwdX_rs,
   output logic        fwdX_rt,
   output logic        fwdM_rs,
   output logic        fwdM_rt,
   output logic        stall,
   output logic [15:0] stall_cnt
);

   localparam int unsigned AW = 5;
   localparam int unsigned BW = 4;
   localparam int unsigned CW = 16;
   localparam logic ENABLE  = 1'b1;
   localparam logic DISABLE = 1'b0;

   typedef struct packed {
      logic [AW-1:0] rd_a;
      logic          reg_write;
      logic          mem_read;
   } shadow_t;

   shadow_t         r_x;
   shadow_t         r_m;
   logic [BW-1:0]   r_mul_busy;
   logic [CW-1:0]   r_stall_cnt;

   logic w_xm_rs;
   logic w_xm_rt;
   logic w_mm_rs;
   logic w_mm_rt;
   logic w_load_use;
   logic w_hilo;
   logic w_hazard;
   logic w_issue;
   shadow_t w_d;

   // Operand matches against the X and M producers; register 0 never matches.
   always_comb begin
      w_xm_rs = d_use_rs & r_x.reg_write & (r_x.rd_a == d_rs_a) & (d_rs_a != AW'(0));
      w_xm_rt = d_use_rt & r_x.reg_write & (r_x.rd_a == d_rt_a) & (d_rt_a != AW'(0));
      w_mm_rs = d_use_rs & r_m.reg_write & (r_m.rd_a == d_rs_a) & (d_rs_a != AW'(0));
      w_mm_rt = d_use_rt & r_m.reg_write & (r_m.rd_a == d_rt_a) & (d_rt_a != AW'(0));
   end

   always_comb begin
      w_load_use = (w_xm_rs | w_xm_rt) & r_x.mem_read;
      w_hilo     = (r_mul_busy != BW'(0)) & (d_use_hilo | d_mul);
      w_hazard   = w_load_use | w_hilo;
      w_issue    = ~w_hazard & ~flush;
      w_d.rd_a      = d_rd_a;
      w_d.reg_write = d_reg_write;
      w_d.mem_read  = d_mem_read;
   end

   // X match wins over M; a load in X cannot forward, it interlocks instead.
   always_comb begin
      fwdX_rs   = DISABLE;
      fwdX_rt   = DISABLE;
      fwdM_rs   = DISABLE;
      fwdM_rt   = DISABLE;
      stall     = ENABLE;
      stall_cnt = CW'(0);
      if (!rst) begin
         fwdX_rs   = w_xm_rs & ~r_x.mem_read;
         fwdX_rt   = w_xm_rt & ~r_x.mem_read;
         fwdM_rs   = w_mm_rs & ~w_xm_rs;
         fwdM_rt   = w_mm_rt & ~w_xm_rt;
         stall     = w_hazard ? DISABLE : ENABLE;
         stall_cnt = r_stall_cnt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_x <= '0;
         r_m <= '0;
      end else begin
         r_m <= r_x;
         r_x <= w_issue ? w_d : shadow_t'('0);
      end
   end

   // Multiply busy countdown; only an issued multiply reloads it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mul_busy <= BW'(0);
      end else if (w_issue && d_mul) begin
         r_mul_busy <= BW'(MUL_LAT - 1);
      end else if (r_mul_busy != BW'(0)) begin
         r_mul_busy <= r_mul_busy - BW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt <= CW'(0);
      end else if (w_hazard && (r_stall_cnt != {CW{1'b1}})) begin
         r_stall_cnt <= r_stall_cnt + CW'(1);
      end
   end

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed scenarios plus random traffic, compared
// every cycle against a time-based pipeline model; a second instance saturates stall_cnt.
module tb_hazard_unit;

   typedef struct packed {
      logic       rst;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       use_rs;
      logic       use_rt;
      logic [4:0] rd;
      logic       wr;
      logic       ld;
      logic       mul;
      logic       hilo;
      logic       flush;
   } din_t;

   typedef struct packed {
      logic [4:0] rd;
      logic       wr;
      logic       ld;
   } stage_t;

   typedef struct packed {
      stage_t      x;
      stage_t      m;
      logic [31:0] now;
      logic [31:0] ready;
      logic [31:0] cnt;
   } mstate_t;

   typedef struct packed {
      logic        fxs;
      logic        fxt;
      logic        fms;
      logic        fmt;
      logic        stall;
      logic [15:0] cnt;
   } out_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   din_t di;
   din_t ds;
   int   passed = 0;
   int   total  = 0;

   logic        fxs, fxt, fms, fmt, st;
   logic [15:0] cnt;
   logic        s_fxs, s_fxt, s_fms, s_fmt, s_st;
   logic [15:0] s_cnt;

   hazard_unit #(.MUL_LAT(4)) dut (
      .clk(clk), .rst(di.rst), .d_rs_a(di.rs), .d_rt_a(di.rt),
      .d_use_rs(di.use_rs), .d_use_rt(di.use_rt), .d_rd_a(di.rd),
      .d_reg_write(di.wr), .d_mem_read(di.ld), .d_mul(di.mul),
      .d_use_hilo(di.hilo), .flush(di.flush),
      .fwdX_rs(fxs), .fwdX_rt(fxt), .fwdM_rs(fms), .fwdM_rt(fmt),
      .stall(st), .stall_cnt(cnt)
   );

   hazard_unit #(.MUL_LAT(15)) dut_sat (
      .clk(clk), .rst(ds.rst), .d_rs_a(ds.rs), .d_rt_a(ds.rt),
      .d_use_rs(ds.use_rs), .d_use_rt(ds.use_rt), .d_rd_a(ds.rd),
      .d_reg_write(ds.wr), .d_mem_read(ds.ld), .d_mul(ds.mul),
      .d_use_hilo(ds.hilo), .flush(ds.flush),
      .fwdX_rs(s_fxs), .fwdX_rt(s_fxt), .fwdM_rs(s_fms), .fwdM_rt(s_fmt),
      .stall(s_st), .stall_cnt(s_cnt)
   );

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
   endtask

   // Model: the last two issued instructions, HI/LO ready time, stall total.
   function automatic out_t mdl_out(input mstate_t s, input din_t d);
      out_t o;
      logic mxs, mxt, mms, mmt, lu, hl;
      o = '0;
      o.stall = 1'b1;
      if (d.rst) return o;
      mxs = d.use_rs && d.rs != 0 && s.x.wr && s.x.rd == d.rs;
      mxt = d.use_rt && d.rt != 0 && s.x.wr && s.x.rd == d.rt;
      mms = d.use_rs && d.rs != 0 && s.m.wr && s.m.rd == d.rs;
      mmt = d.use_rt && d.rt != 0 && s.m.wr && s.m.rd == d.rt;
      lu  = (mxs || mxt) && s.x.ld;
      hl  = (s.now < s.ready) && (d.hilo || d.mul);
      o.fxs   = mxs && !s.x.ld;
      o.fxt   = mxt && !s.x.ld;
      o.fms   = mms && !mxs;
      o.fmt   = mmt && !mxt;
      o.stall = !(lu || hl);
      o.cnt   = 16'(s.cnt);
      return o;
   endfunction

   function automatic mstate_t mdl_step(input mstate_t s, input din_t d, input int lat);
      out_t o;
      o = mdl_out(s, d);
      if (d.rst) begin
         s.x = '0;
         s.m = '0;
         s.ready = 32'd0;
         s.cnt = 32'd0;
      end else begin
         if (!o.stall && s.cnt < 32'd65535) s.cnt = s.cnt + 32'd1;
         s.m = s.x;
         if (o.stall && !d.flush) begin
            s.x.rd = d.rd;
            s.x.wr = d.wr;
            s.x.ld = d.ld;
            if (d.mul) s.ready = s.now + 32'(lat);
         end else begin
            s.x = '0;
         end
      end
      s.now = s.now + 32'd1;
      return s;
   endfunction

   mstate_t ms  = '0;
   mstate_t mss = '0;
   out_t    eo;
   out_t    eso;

   // Every-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      eo  = mdl_out(ms, di);
      eso = mdl_out(mss, ds);
      chk("fwdX_rs", int'(fxs), int'(eo.fxs));
      chk("fwdX_rt", int'(fxt), int'(eo.fxt));
      chk("fwdM_rs", int'(fms), int'(eo.fms));
      chk("fwdM_rt", int'(fmt), int'(eo.fmt));
      chk("stall", int'(st), int'(eo.stall));
      chk("stall_cnt", int'(cnt), int'(eo.cnt));
      chk("sat_stall", int'(s_st), int'(eso.stall));
      chk("sat_stall_cnt", int'(s_cnt), int'(eso.cnt));
      ms  = mdl_step(ms, di, 4);
      mss = mdl_step(mss, ds, 15);
   end

   task automatic cyc(input din_t v);
      @(posedge clk);
      #1;
      di = v;
      #3;
   endtask

   function automatic din_t alu(input logic [4:0] rd);
      din_t v;
      v = '0; v.rd = rd; v.wr = 1'b1;
      return v;
   endfunction
   function automatic din_t lw(input logic [4:0] rd);
      din_t v;
      v = alu(rd); v.ld = 1'b1;
      return v;
   endfunction
   function automatic din_t urs(input logic [4:0] rs);
      din_t v;
      v = '0; v.rs = rs; v.use_rs = 1'b1;
      return v;
   endfunction
   function automatic din_t urt(input logic [4:0] rt);
      din_t v;
      v = '0; v.rt = rt; v.use_rt = 1'b1;
      return v;
   endfunction
   function automatic din_t mulop();
      din_t v;
      v = '0; v.mul = 1'b1;
      return v;
   endfunction
   function automatic din_t hilo();
      din_t v;
      v = '0; v.hilo = 1'b1;
      return v;
   endfunction

   task automatic main_seq();
      din_t v;
      v = alu(5); v.rst = 1'b1;
      repeat (3) cyc(v);
      chk("rst_stall", int'(st), 1);
      chk("rst_cnt", int'(cnt), 0);
      chk("rst_fwdX", int'(fxs), 0);
      // ALU producer forwarded from X, then from M.
      cyc(alu(5));
      cyc(urs(5));
      chk("alu_fwdX_rs", int'(fxs), 1);
      chk("alu_stall", int'(st), 1);
      cyc(urt(5));
      chk("alu_fwdM_rt", int'(fmt), 1);
      chk("alu_fwdX_rt", int'(fxt), 0);
      // Load-use interlock for one cycle.
      cyc(lw(7));
      cyc(urs(7));
      chk("lu_stall", int'(st), 0);
      chk("lu_fwdX", int'(fxs), 0);
      cyc(urs(7));
      chk("lu_stall2", int'(st), 1);
      chk("lu_fwdM", int'(fms), 1);
      chk("lu_cnt", int'(cnt), 1);
      // Register 0 and X-over-M priority.
      cyc(alu(0));
      cyc(alu(0));
      v = urs(0); v.use_rt = 1'b1;
      cyc(v);
      chk("r0_fwdX_rs", int'(fxs), 0);
      chk("r0_fwdM_rs", int'(fms), 0);
      chk("r0_fwdX_rt", int'(fxt), 0);
      chk("r0_fwdM_rt", int'(fmt), 0);
      cyc(alu(3));
      cyc(alu(3));
      cyc(urs(3));
      chk("pri_fwdX", int'(fxs), 1);
      chk("pri_fwdM", int'(fms), 0);
      // Multiply then HI/LO read: three interlock cycles.
      cyc(mulop());
      for (int i = 0; i < 3; i++) begin
         cyc(hilo());
         chk("mul_stall", int'(st), 0);
      end
      cyc(hilo());
      chk("mul_release", int'(st), 1);
      chk("mul_cnt", int'(cnt), 4);
      cyc(mulop());
      chk("mul2_issue", int'(st), 1);
      cyc(mulop());
      chk("mul2_stall", int'(st), 0);
      repeat (4) cyc('0);
      // Flushed producer and flushed multiply leave no trace.
      v = alu(9); v.flush = 1'b1;
      cyc(v);
      cyc(urs(9));
      chk("fl_fwdX", int'(fxs), 0);
      chk("fl_fwdM", int'(fms), 0);
      v = mulop(); v.flush = 1'b1;
      cyc(v);
      cyc(hilo());
      chk("fl_mul", int'(st), 1);
      // Reset abandons a load-use stall and a multiply.
      cyc(lw(7));
      cyc(urs(7));
      chk("rlu_stall", int'(st), 0);
      v = urs(7); v.rst = 1'b1;
      cyc(v);
      chk("rlu_rst_stall", int'(st), 1);
      chk("rlu_rst_cnt", int'(cnt), 0);
      cyc(urs(7));
      chk("rlu_after_stall", int'(st), 1);
      chk("rlu_after_cnt", int'(cnt), 0);
      cyc(mulop());
      v = hilo(); v.rst = 1'b1;
      cyc(v);
      cyc(hilo());
      chk("rmul_after", int'(st), 1);
      // Random traffic on a narrow register range to provoke matches.
      for (int i = 0; i < 20000; i++) begin
         v.rst    = ($urandom_range(0, 299) == 0);
         v.rs     = 5'($urandom_range(0, 3));
         v.rt     = 5'($urandom_range(0, 3));
         v.use_rs = ($urandom_range(0, 3) != 0);
         v.use_rt = ($urandom_range(0, 3) != 0);
         v.rd     = 5'($urandom_range(0, 3));
         v.wr     = ($urandom_range(0, 3) != 0);
         v.ld     = ($urandom_range(0, 2) == 0);
         v.mul    = ($urandom_range(0, 5) == 0);
         v.hilo   = ($urandom_range(0, 3) == 0);
         v.flush  = ($urandom_range(0, 7) == 0);
         cyc(v);
      end
   endtask

   task automatic sat_seq();
      repeat (2) @(posedge clk);
      #1;
      ds.rst = 1'b0;
      repeat (70400) @(posedge clk);
      #4;
      chk("sat_final", int'(s_cnt), 32'hFFFF);
   endtask

   initial begin
      di = '0;
      di.rst = 1'b1;
      ds = '0;
      ds.rst = 1'b1;
      ds.mul = 1'b1;
      ds.hilo = 1'b1;
      fork
         main_seq();
         sat_seq();
      join
      @(posedge clk);
      #1;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
